// File: rtl/ext_hold_ctrl_pkg.sv
// Shared types for the external-control hold block.
//   ext_ctrl_state_t : FSM state encoding (RUN, DRAIN, HALTED, SLEEP, RESTART)
//   park_reason_t    : why the pipeline is being drained (debug halt or wait instruction)
//   restart_load()   : restart counter load value for a given restart length
package ext_hold_ctrl_pkg;

  typedef logic [2:0] ext_ctrl_state_t;

  localparam ext_ctrl_state_t StRun     = 3'd0;
  localparam ext_ctrl_state_t StDrain   = 3'd1;
  localparam ext_ctrl_state_t StHalted  = 3'd2;
  localparam ext_ctrl_state_t StSleep   = 3'd3;
  localparam ext_ctrl_state_t StRestart = 3'd4;

  typedef enum logic {
    ReasonHalt  = 1'b0,
    ReasonSleep = 1'b1
  } park_reason_t;

  // Restart length is at most 15 cycles, so a 4-bit down-counter suffices.
  localparam int unsigned RestartCntW = 4;

  // The counter is loaded with length-1 and RESTART is left when it reads zero,
  // so RESTART lasts exactly `cycles` cycles.
  function automatic logic [RestartCntW-1:0] restart_load(input int unsigned cycles);
    return RestartCntW'(cycles - 32'd1);
  endfunction

endpackage

// File: rtl/ext_hold_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   : clock
//   reset : asynchronous active-low reset, clears the count
//   clr   : synchronous clear (priority over en)
//   en    : increment by one this cycle, sticking at all-ones
//   count : current count
module ext_hold_ctrl_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ext_hold_ctrl.sv
// External-control hold and wakeup generation for the decode stage.
// Arbitrates a level debugger halt against a wait-instruction sleep, drains the
// pipeline before parking, and restarts decode on halt release or wake event.
// Ports:
//   clk        : core clock
//   reset      : asynchronous active-low reset
//   halt_req   : debugger halt request (level)
//   sleep_req  : wait instruction reached decode (single-cycle pulse)
//   pipe_empty : nothing in flight, load/store unit ready
//   event_in   : wake event (level or pulse)
//   hold_ext   : hold request to decode
//   wakeup     : one-cycle pulse at the start of a restart
//   halted     : parked by debugger
//   sleeping   : parked by wait instruction
//   sleep_cnt  : total cycles spent asleep, saturating
// All outputs are decoded from registered state only.
module ext_hold_ctrl
  import ext_hold_ctrl_pkg::*;
#(
  parameter int unsigned RESTART_CYCLES = 2,  // legal range 1..15
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt_req,
  input  logic             sleep_req,
  input  logic             pipe_empty,
  input  logic             event_in,
  output logic             hold_ext,
  output logic             wakeup,
  output logic             halted,
  output logic             sleeping,
  output logic [CNT_W-1:0] sleep_cnt
);

  localparam logic [RestartCntW-1:0] RestartLoad = restart_load(RESTART_CYCLES);

  ext_ctrl_state_t        state_q, state_d;
  park_reason_t           reason_q, reason_d;
  park_reason_t           reason_eff;
  logic                   evt_q, evt_d;
  logic [RestartCntW-1:0] rcnt_q, rcnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StRun;
      reason_q <= ReasonHalt;
      evt_q    <= 1'b0;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      reason_q <= reason_d;
      evt_q    <= evt_d;
      rcnt_q   <= rcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    reason_d   = reason_q;
    evt_d      = evt_q;
    rcnt_d     = rcnt_q;
    reason_eff = reason_q;

    unique case (state_q)
      StRun: begin
        // Halt wins over a simultaneous sleep request; the sleep is dropped.
        if (halt_req) begin
          state_d  = StDrain;
          reason_d = ReasonHalt;
        end else if (sleep_req) begin
          state_d  = StDrain;
          reason_d = ReasonSleep;
        end
      end

      StDrain: begin
        reason_eff = halt_req ? ReasonHalt : reason_q;
        reason_d   = reason_eff;
        if ((reason_eff == ReasonSleep) && event_in) begin
          evt_d = 1'b1;
        end
        if (pipe_empty) begin
          evt_d = 1'b0;
          if (reason_eff == ReasonHalt) begin
            state_d = StHalted;
          end else if (evt_q || event_in) begin
            // Wake event arrived while draining: skip SLEEP altogether.
            state_d = StRestart;
            rcnt_d  = RestartLoad;
          end else begin
            state_d = StSleep;
          end
        end
      end

      StHalted: begin
        if (!halt_req) begin
          state_d = StRestart;
          rcnt_d  = RestartLoad;
        end
      end

      StSleep: begin
        // Pipeline is already empty, so a halt parks directly.
        if (halt_req) begin
          state_d  = StHalted;
          reason_d = ReasonHalt;
        end else if (event_in) begin
          state_d = StRestart;
          rcnt_d  = RestartLoad;
        end
      end

      StRestart: begin
        if (halt_req) begin
          state_d  = StDrain;
          reason_d = ReasonHalt;
        end else if (rcnt_q == '0) begin
          state_d = StRun;
        end else begin
          rcnt_d = rcnt_q - RestartCntW'(1);
        end
      end

      default: begin
        state_d = StRun;
      end
    endcase
  end

  assign hold_ext = (state_q != StRun);
  assign halted   = (state_q == StHalted);
  assign sleeping = (state_q == StSleep);
  // Counter still holds its load value only in the first restart cycle.
  assign wakeup   = (state_q == StRestart) && (rcnt_q == RestartLoad);

  ext_hold_ctrl_sat_counter #(
    .Width(CNT_W)
  ) u_sleep_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (1'b0),
    .en   (state_q == StSleep),
    .count(sleep_cnt)
  );

endmodule

// File: tb/tb_ext_hold_ctrl.sv
module tb_ext_hold_ctrl;

  localparam int unsigned CntW = 4;

  // Expected {hold_ext, wakeup, halted, sleeping}
  localparam logic [3:0] ERun  = 4'b0000;
  localparam logic [3:0] EDrn  = 4'b1000;
  localparam logic [3:0] EHlt  = 4'b1010;
  localparam logic [3:0] ESlp  = 4'b1001;
  localparam logic [3:0] EWake = 4'b1100;
  localparam logic [3:0] ERst  = 4'b1000;

  typedef struct packed {
    logic [3:0]      flags;
    logic [CntW-1:0] cnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            halt_req = 1'b0;
  logic            sleep_req = 1'b0;
  logic            pipe_empty = 1'b0;
  logic            event_in = 1'b0;
  logic            hold_ext, wakeup, halted, sleeping;
  logic [CntW-1:0] sleep_cnt;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cycle = 0;
  exp_t sb_q[$];
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  ext_hold_ctrl #(
    .RESTART_CYCLES(2),
    .CNT_W         (CntW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .halt_req  (halt_req),
    .sleep_req (sleep_req),
    .pipe_empty(pipe_empty),
    .event_in  (event_in),
    .hold_ext  (hold_ext),
    .wakeup    (wakeup),
    .halted    (halted),
    .sleeping  (sleeping),
    .sleep_cnt (sleep_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  // Drive one cycle of inputs, push what the outputs must be after the edge,
  // then pop and compare once the DUT has produced them.
  task automatic cyc(input logic h, input logic s, input logic p, input logic e,
                     input logic [3:0] flags);
    exp_t x;
    halt_req   = h;
    sleep_req  = s;
    pipe_empty = p;
    event_in   = e;
    x.flags    = flags;
    x.cnt      = CntW'(exp_cnt);
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    cycle++;
    x = sb_q.pop_front();
    check_eq("hold_ext", 32'(hold_ext), 32'(x.flags[3]));
    check_eq("wakeup", 32'(wakeup), 32'(x.flags[2]));
    check_eq("halted", 32'(halted), 32'(x.flags[1]));
    check_eq("sleeping", 32'(sleeping), 32'(x.flags[0]));
    check_eq("sleep_cnt", 32'(sleep_cnt), 32'(x.cnt));
  endtask

  // Sleep cycles accumulate into the expected count, saturating at 4-bit max.
  task automatic slept();
    if (exp_cnt < 15) exp_cnt++;
  endtask

  initial begin
    #2;
    check_eq("rst_hold", 32'(hold_ext), 32'd0);
    check_eq("rst_wakeup", 32'(wakeup), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_sleeping", 32'(sleeping), 32'd0);
    check_eq("rst_cnt", 32'(sleep_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 0, 0, 0, ERun);

    // Sleep, pipe empties on the third drain cycle, wake after 10 sleep cycles.
    cyc(0, 1, 0, 0, EDrn);
    cyc(0, 0, 0, 0, EDrn);
    cyc(0, 0, 0, 0, EDrn);
    cyc(0, 0, 1, 0, ESlp);
    for (int i = 0; i < 9; i++) begin
      slept();
      cyc(0, 0, 1, 0, ESlp);
    end
    slept();
    cyc(0, 0, 1, 1, EWake);
    cyc(0, 0, 1, 0, ERst);
    cyc(0, 0, 1, 0, ERun);
    check_eq("cnt_after_sleep", 32'(sleep_cnt), 32'd10);

    // Debug halt held 20 cycles with pipe already empty.
    cyc(1, 0, 1, 0, EDrn);
    for (int i = 0; i < 19; i++) cyc(1, 0, 1, 0, EHlt);
    cyc(0, 0, 1, 0, EWake);
    cyc(0, 0, 1, 0, ERst);
    cyc(0, 0, 1, 0, ERun);

    // Halt and sleep together: halt wins, never sleeps.
    cyc(1, 1, 1, 0, EDrn);
    cyc(1, 0, 1, 0, EHlt);
    cyc(1, 0, 1, 0, EHlt);
    cyc(0, 0, 1, 0, EWake);
    cyc(0, 0, 1, 0, ERst);
    cyc(0, 0, 1, 0, ERun);

    // Wake event during drain cancels the sleep.
    cyc(0, 1, 0, 0, EDrn);
    cyc(0, 0, 0, 1, EDrn);
    cyc(0, 0, 0, 0, EDrn);
    cyc(0, 0, 1, 0, EWake);
    cyc(0, 0, 1, 0, ERst);
    cyc(0, 0, 1, 0, ERun);

    // Halt arriving while asleep parks immediately.
    cyc(0, 1, 1, 0, EDrn);
    cyc(0, 0, 1, 0, ESlp);
    slept();
    cyc(0, 0, 1, 0, ESlp);
    slept();
    cyc(1, 0, 1, 0, EHlt);
    cyc(1, 0, 1, 0, EHlt);
    cyc(0, 0, 1, 0, EWake);
    cyc(1, 0, 1, 0, EDrn);  // halt during restart goes back to drain
    cyc(1, 0, 1, 0, EHlt);
    cyc(0, 0, 1, 0, EWake);
    cyc(0, 0, 1, 0, ERst);
    cyc(0, 0, 1, 0, ERun);

    // Long sleep saturates the 4-bit counter, then reset mid-sleep.
    cyc(0, 1, 1, 0, EDrn);
    cyc(0, 0, 1, 0, ESlp);
    for (int i = 0; i < 20; i++) begin
      slept();
      cyc(0, 0, 1, 0, ESlp);
    end
    check_eq("cnt_saturated", 32'(sleep_cnt), 32'd15);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_hold", 32'(hold_ext), 32'd0);
    check_eq("async_wakeup", 32'(wakeup), 32'd0);
    check_eq("async_sleeping", 32'(sleeping), 32'd0);
    check_eq("async_halted", 32'(halted), 32'd0);
    check_eq("async_cnt", 32'(sleep_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_cnt = 0;
    cyc(0, 0, 1, 0, ERun);
    cyc(0, 0, 1, 1, ERun);  // events ignored in RUN
    cyc(0, 1, 1, 0, EDrn);
    cyc(0, 0, 1, 0, ESlp);
    slept();
    cyc(0, 0, 1, 1, EWake);
    cyc(0, 0, 1, 0, ERst);
    cyc(0, 0, 1, 0, ERun);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
